parametric_interrupt_controller_core: RTL

//  Clocked, parametrised successor to the 8259A control logic. Holds IRR/ISR/IMR for NUM_IRQ request lines,

---
 rtl/parametric_interrupt_controller_core.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/parametric_interrupt_controller_core.sv
// Parametrised 8259A-style interrupt controller core: IRR/ISR bookkeeping, fixed or
// rotating priority with full nesting, two-pulse INTA sequence, poll command and EOI.
module parametric_interrupt_controller_core #(
  parameter int unsigned NUM_IRQ      = 8,
  parameter int unsigned ID_WIDTH     = 3,
  parameter int unsigned VECTOR_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_IRQ-1:0]      interrupt_request,
  input  logic                    level_or_edge_triggered_config,
  input  logic [NUM_IRQ-1:0]      interrupt_mask,
  input  logic                    auto_eoi_config,
  input  logic                    rotate_on_eoi,
  input  logic                    eoi_strobe,
  input  logic                    specific_eoi_strobe,
  input  logic [ID_WIDTH-1:0]     eoi_id,
  input  logic                    poll_strobe,
  input  logic                    read_strobe,
  input  logic                    interrupt_acknowledge_n,
  input  logic [VECTOR_WIDTH-1:0] vector_base,
  output logic                    interrupt_to_cpu,
  output logic [VECTOR_WIDTH-1:0] vector_out,
  output logic                    vector_valid,
  output logic [7:0]              poll_data,
  output logic [NUM_IRQ-1:0]      interrupt_request_register,
  output logic [NUM_IRQ-1:0]      in_service_register
);

  typedef enum logic [1:0] {StIdle, StAck1, StAck2, StPoll} state_e;

  state_e                  state_q, state_d;
  logic [NUM_IRQ-1:0]      ir_prev_q;
  logic [NUM_IRQ-1:0]      irr_q, irr_d;
  logic [NUM_IRQ-1:0]      isr_q, isr_d;
  logic [ID_WIDTH-1:0]     lowest_q, lowest_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic                    spurious_q, spurious_d;
  logic                    int_req_q, int_req_d;
  logic                    vv_q, vv_d;
  logic [VECTOR_WIDTH-1:0] vec_q, vec_d;
  logic [7:0]              poll_q, poll_d;
  logic                    inta_prev_q;

  logic                    inta_fall, inta_rise;
  logic [NUM_IRQ-1:0]      cand;
  logic [ID_WIDTH-1:0]     win_id, isr_top_id, id_k;
  int                      win_rank, isr_rank, idx;
  logic                    win_valid, isr_any;

  assign inta_fall = inta_prev_q & ~interrupt_acknowledge_n;
  assign inta_rise = ~inta_prev_q & interrupt_acknowledge_n;
  assign cand      = irr_q & ~interrupt_mask;

  // Rotated priority search; rank 0 is the line just after lowest_q.
  always_comb begin
    win_id     = '0;
    isr_top_id = '0;
    win_rank   = int'(NUM_IRQ);
    isr_rank   = int'(NUM_IRQ);
    idx        = 0;
    id_k       = '0;
    // Walk from lowest to highest priority so the last hit is the best one.
    for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
      idx = int'(lowest_q) + 1 + k;
      if (idx >= int'(NUM_IRQ)) idx = idx - int'(NUM_IRQ);
      id_k = ID_WIDTH'(idx);
      if (cand[id_k]) begin
        win_id   = id_k;
        win_rank = k;
      end
      if (isr_q[id_k]) begin
        isr_top_id = id_k;
        isr_rank   = k;
      end
    end
    // Fully nested: the winner must strictly outrank everything in service.
    win_valid = (win_rank < isr_rank);
    isr_any   = (isr_rank < int'(NUM_IRQ));
  end

  // Sequencer, ISR/IRR next state, EOI handling and INT generation.
  always_comb begin
    logic [NUM_IRQ-1:0] isr_set, isr_clr, irr_clr;
    logic               latch;
    state_d    = state_q;
    id_d       = id_q;
    spurious_d = spurious_q;
    vv_d       = vv_q;
    vec_d      = vec_q;
    poll_d     = poll_q;
    lowest_d   = lowest_q;
    isr_set    = '0;
    isr_clr    = '0;
    irr_clr    = '0;
    latch      = 1'b0;

    case (state_q)
      StIdle: begin
        // INTA takes precedence over a simultaneous poll command.
        if (inta_fall) begin
          state_d = StAck1;
          latch   = 1'b1;
        end else if (poll_strobe) begin
          state_d = StPoll;
          latch   = 1'b1;
        end
      end
      StAck1: begin
        if (inta_rise) state_d = StAck2;
      end
      StAck2: begin
        if (inta_fall) begin
          vv_d                  = 1'b1;
          vec_d                 = vector_base;
          vec_d[ID_WIDTH-1:0]   = id_q;
        end else if (inta_rise) begin
          state_d = StIdle;
          vv_d    = 1'b0;
          vec_d   = '0;
          // A spurious acknowledge never set an ISR bit, so there is nothing to retire.
          if (auto_eoi_config && !spurious_q) begin
            isr_clr[id_q] = 1'b1;
            if (rotate_on_eoi) lowest_d = id_q;
          end
        end
      end
      StPoll: begin
        if (read_strobe) begin
          state_d = StIdle;
          poll_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (latch) begin
      id_d       = win_valid ? win_id : ID_WIDTH'(NUM_IRQ - 1);
      spurious_d = ~win_valid;
      if (win_valid) begin
        isr_set[win_id] = 1'b1;
        irr_clr[win_id] = 1'b1;
      end
      if (state_d == StPoll) begin
        poll_d                 = '0;
        poll_d[7]              = win_valid;
        poll_d[ID_WIDTH-1:0]   = id_d;
      end
    end

    if (eoi_strobe && isr_any) begin
      isr_clr[isr_top_id] = 1'b1;
      if (rotate_on_eoi) lowest_d = isr_top_id;
    end
    if (specific_eoi_strobe && (int'(eoi_id) < int'(NUM_IRQ))) begin
      isr_clr[eoi_id] = 1'b1;
    end

    isr_d = (isr_q | isr_set) & ~isr_clr;

    // A fresh edge in the clearing cycle keeps the bit set.
    if (level_or_edge_triggered_config) begin
      irr_d = interrupt_request & ~irr_clr;
    end else begin
      irr_d = (irr_q & ~irr_clr) | (interrupt_request & ~ir_prev_q);
    end

    int_req_d = (state_q == StIdle) && (state_d == StIdle) && win_valid;
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ir_prev_q   <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      lowest_q    <= ID_WIDTH'(NUM_IRQ - 1);
      id_q        <= '0;
      spurious_q  <= 1'b0;
      int_req_q   <= 1'b0;
      vv_q        <= 1'b0;
      vec_q       <= '0;
      poll_q      <= '0;
      inta_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ir_prev_q   <= interrupt_request;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      lowest_q    <= lowest_d;
      id_q        <= id_d;
      spurious_q  <= spurious_d;
      int_req_q   <= int_req_d;
      vv_q        <= vv_d;
      vec_q       <= vec_d;
      poll_q      <= poll_d;
      inta_prev_q <= interrupt_acknowledge_n;
    end
  end

  assign interrupt_to_cpu           = int_req_q;
  assign vector_out                 = vec_q;
  assign vector_valid               = vv_q;
  assign poll_data                  = poll_q;
  assign interrupt_request_register = irr_q;
  assign in_service_register        = isr_q;

endmodule
